user_timer_arbiter: RTL and testbench

- Shares the user-domain advanced-timer OBI subordinate (0x2000_1000, 4 KiB) between NumMgr requesting managers, e.g. the core-side user demux port and an event/DMA manager.
- Arbitrates requests round-robin and locks a pending request until it is granted.
- Tracks outstanding transactions in an index FIFO and routes in-order responses back to the issuing manager.
- Sits between the managers and the timer subordinate port in the user domain.

---
 rtl/user_pkg.sv | 13 +
 rtl/user_timer_arbiter_if.sv | 41 ++++
 rtl/user_timer_arb_idx_fifo.sv | 54 +++++
 rtl/user_timer_arbiter.sv | 91 +++++++++
 tb/tb_user_timer_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/user_pkg.sv
// User-domain shared constants and types: manager count, timer arbiter depth,
// and the advanced-timer address window.
package user_pkg;

  localparam int unsigned NumUserMgr           = 2;
  localparam int unsigned UserTimerArbMaxTrans = 4;

  localparam logic [31:0] UserAdvTimerBaseAddr = 32'h2000_1000;
  localparam logic [31:0] UserAdvTimerSize     = 32'h0000_1000;

  typedef logic [$clog2(NumUserMgr)-1:0] user_mgr_idx_t;

endpackage

// File: rtl/user_timer_arbiter_if.sv
// OBI bundle between the managers, the timer arbiter and the timer subordinate.
// The arbiter binds the slave view; the surrounding environment binds master.
interface user_timer_arbiter_if import user_pkg::*; #(
  parameter int unsigned NumMgr    = NumUserMgr,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [NumMgr-1:0]                    mgr_req_i;
  logic [NumMgr-1:0]                    mgr_gnt_o;
  logic [NumMgr-1:0][AddrWidth-1:0]     mgr_addr_i;
  logic [NumMgr-1:0]                    mgr_we_i;
  logic [NumMgr-1:0][DataWidth/8-1:0]   mgr_be_i;
  logic [NumMgr-1:0][DataWidth-1:0]     mgr_wdata_i;
  logic [NumMgr-1:0]                    mgr_rvalid_o;
  logic [DataWidth-1:0]                 mgr_rdata_o;
  logic                                 mgr_err_o;

  logic                                 sbr_req_o;
  logic                                 sbr_gnt_i;
  logic [AddrWidth-1:0]                 sbr_addr_o;
  logic                                 sbr_we_o;
  logic [DataWidth/8-1:0]               sbr_be_o;
  logic [DataWidth-1:0]                 sbr_wdata_o;
  logic                                 sbr_rvalid_i;
  logic [DataWidth-1:0]                 sbr_rdata_i;
  logic                                 sbr_err_i;

  modport slave (
    input  mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
           sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i,
    output mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
           sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o
  );

  modport master (
    output mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
           sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i,
    input  mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
           sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o
  );
endinterface

// File: rtl/user_timer_arb_idx_fifo.sv
// In-order FIFO of issuing-manager indices for outstanding timer transactions.
module user_timer_arb_idx_fifo import user_pkg::*; #(
  parameter int unsigned Depth = UserTimerArbMaxTrans,
  parameter type         T     = user_mgr_idx_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] usage_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  T                  r_mem [Depth];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_cnt;
  logic              w_push, w_pop;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign usage_o = r_cnt;
  assign data_o  = r_mem[r_rptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop)  r_rptr <= nxt(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/user_timer_arbiter.sv
// Round-robin arbiter sharing the user advanced-timer OBI port; a pending request
// is locked until granted and in-order responses are routed back by index FIFO.
module user_timer_arbiter import user_pkg::*; #(
  parameter int unsigned NumMgr    = NumUserMgr,
  parameter int unsigned MaxTrans  = UserTimerArbMaxTrans,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  user_timer_arbiter_if.slave       bus,
  output logic [$clog2(MaxTrans):0] outstanding_o,
  output logic                      protocol_err_o
);
  localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  typedef logic [IdxW-1:0] idx_t;

  idx_t r_rr, r_lock_idx, w_winner, w_head;
  logic r_lock, r_perr;
  logic w_full, w_empty, w_hs, w_rsp;

  // Scan from the highest offset down so the nearest requester at/after rr wins.
  always_comb begin
    int   j;
    idx_t c;
    j        = 0;
    c        = '0;
    w_winner = r_rr;
    if (r_lock) begin
      w_winner = r_lock_idx;
    end else begin
      for (int k = int'(NumMgr) - 1; k >= 0; k--) begin
        j = int'(r_rr) + k;
        if (j >= int'(NumMgr)) j = j - int'(NumMgr);
        c = idx_t'(j);
        if (bus.mgr_req_i[c]) w_winner = c;
      end
    end
  end

  // Full blocks new requests even when a pop lands in the same cycle.
  assign bus.sbr_req_o   = (|bus.mgr_req_i) && !w_full;
  assign w_hs            = bus.sbr_req_o && bus.sbr_gnt_i;
  assign w_rsp           = bus.sbr_rvalid_i && !w_empty;

  assign bus.sbr_addr_o  = bus.mgr_addr_i[w_winner];
  assign bus.sbr_we_o    = bus.mgr_we_i[w_winner];
  assign bus.sbr_be_o    = bus.mgr_be_i[w_winner];
  assign bus.sbr_wdata_o = bus.mgr_wdata_i[w_winner];
  assign bus.mgr_rdata_o = bus.sbr_rdata_i;
  assign bus.mgr_err_o   = bus.sbr_err_i;
  assign protocol_err_o  = r_perr;

  for (genvar gi = 0; gi < NumMgr; gi++) begin : g_mgr
    assign bus.mgr_gnt_o[gi]    = w_hs  && (w_winner == idx_t'(gi));
    assign bus.mgr_rvalid_o[gi] = w_rsp && (w_head   == idx_t'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_perr     <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr   <= (w_winner == idx_t'(NumMgr - 1)) ? '0 : w_winner + idx_t'(1);
        r_lock <= 1'b0;
      end else if (bus.sbr_req_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_winner;
      end
      if (bus.sbr_rvalid_i && w_empty) r_perr <= 1'b1;
    end
  end

  user_timer_arb_idx_fifo #(
    .Depth (MaxTrans),
    .T     (idx_t)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_hs),
    .data_i  (w_winner),
    .pop_i   (w_rsp),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .usage_o (outstanding_o)
  );
endmodule

// File: tb/tb_user_timer_arbiter.sv
// Bench for user_timer_arbiter: reference arbitration model with an in-order
// scoreboard of issuing managers, popped as responses come back.
module tb_user_timer_arbiter;
  import user_pkg::*;

  localparam int NM = 2;
  localparam int MT = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  user_timer_arbiter_if #(.NumMgr(NM), .AddrWidth(AW), .DataWidth(DW)) bus ();
  logic [$clog2(MT):0] outstanding;
  logic                perr;

  user_timer_arbiter #(
    .NumMgr(NM), .MaxTrans(MT), .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .outstanding_o  (outstanding),
    .protocol_err_o (perr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // reference model state; sb holds issuing-manager indices in grant order
  int m_rr;
  bit m_lock;
  int m_lidx;
  bit m_perr;
  int sb[$];

  function automatic logic [31:0] addr_of(input int i);
    return UserAdvTimerBaseAddr + 32'(4 * i);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.mgr_req_i    = '0;
    bus.sbr_gnt_i    = 1'b0;
    bus.sbr_rvalid_i = 1'b0;
    bus.sbr_rdata_i  = '0;
    bus.sbr_err_i    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.mgr_gnt_o, 0);
    chk("rst_req", bus.sbr_req_o, 0);
    chk("rst_rvalid", bus.mgr_rvalid_o, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_perr", perr, 0);
    m_rr = 0; m_lock = 0; m_lidx = 0; m_perr = 0;
    sb.delete();
    rst = 1'b0;
  endtask

  // Drive one cycle's inputs, check combinational/registered outputs against model.
  task automatic cyc(input logic [NM-1:0] req, input bit gnt, input bit rv,
                     input logic [31:0] rd, input bit er);
    int w;
    bit exp_req, hs, rsp;
    logic [NM-1:0] eg, erv;
    bus.mgr_req_i    = req;
    bus.sbr_gnt_i    = gnt;
    bus.sbr_rvalid_i = rv;
    bus.sbr_rdata_i  = rd;
    bus.sbr_err_i    = er;
    #1;
    w = m_rr;
    if (m_lock) w = m_lidx;
    else for (int k = NM - 1; k >= 0; k--) if (req[(m_rr + k) % NM]) w = (m_rr + k) % NM;
    exp_req = (|req) && (sb.size() < MT);
    hs  = exp_req && gnt;
    rsp = rv && (sb.size() > 0);
    eg = '0;  if (hs)  eg[w] = 1'b1;
    erv = '0; if (rsp) erv[sb[0]] = 1'b1;
    chk("sbr_req", bus.sbr_req_o, exp_req);
    chk("mgr_gnt", bus.mgr_gnt_o, eg);
    chk("mgr_rvalid", bus.mgr_rvalid_o, erv);
    chk("outstanding", outstanding, sb.size());
    chk("perr", perr, m_perr);
    if (exp_req) begin
      chk("sbr_addr", bus.sbr_addr_o, addr_of(w));
      chk("sbr_we", bus.sbr_we_o, (w % 2) == 1);
      chk("sbr_be", bus.sbr_be_o, 4'hF >> w);
      chk("sbr_wdata", bus.sbr_wdata_o, 32'hD000_0000 + 32'(w));
    end
    if (rsp) begin
      chk("rdata", bus.mgr_rdata_o, rd);
      chk("err", bus.mgr_err_o, er);
      void'(sb.pop_front());
    end
    if (rv && !rsp) m_perr = 1;
    if (hs) begin
      sb.push_back(w);
      m_rr = (w + 1) % NM;
      m_lock = 0;
    end else if (exp_req) begin
      m_lock = 1;
      m_lidx = w;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 2 * MT) begin
      cyc('0, 1'b0, 1'b1, 32'h0000_0F00 + 32'(guard), 1'b0);
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", outstanding, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NM; i++) begin
      bus.mgr_addr_i[i]  = addr_of(i);
      bus.mgr_we_i[i]    = (i % 2) == 1;
      bus.mgr_be_i[i]    = 4'hF >> i;
      bus.mgr_wdata_i[i] = 32'hD000_0000 + 32'(i);
    end
    do_reset();

    // round-robin fairness with one response per cycle
    for (int k = 0; k < 6; k++) begin
      cyc(2'b11, 1'b1, k > 0, 32'h100 + 32'(k), 1'b0);
      chk("rr_order", bus.mgr_gnt_o, (k % 2) ? 2 : 1);
      chk("rr_addr", bus.sbr_addr_o, (k % 2) ? 32'h2000_1004 : 32'h2000_1000);
      @(negedge clk);
    end
    drain();

    // lock holds mgr 1 while ungranted, even after mgr 0 joins
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(2'b10, 1'b0, 1'b0, '0, 1'b0);
      chk("lock_addr", bus.sbr_addr_o, 32'h2000_1004);
      @(negedge clk);
    end
    cyc(2'b11, 1'b0, 1'b0, '0, 1'b0);
    chk("lock_addr_both", bus.sbr_addr_o, 32'h2000_1004);
    @(negedge clk);
    cyc(2'b11, 1'b1, 1'b0, '0, 1'b0);
    chk("lock_gnt_first", bus.mgr_gnt_o, 2'b10);
    @(negedge clk);
    cyc(2'b11, 1'b1, 1'b0, '0, 1'b0);
    chk("lock_gnt_next", bus.mgr_gnt_o, 2'b01);
    @(negedge clk);
    drain();

    // full FIFO blocks requests, including the cycle of a pop
    do_reset();
    repeat (MT) begin
      cyc(2'b01, 1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
    end
    cyc(2'b01, 1'b1, 1'b0, '0, 1'b0);
    chk("full_outstanding", outstanding, 4);
    chk("full_req", bus.sbr_req_o, 0);
    @(negedge clk);
    cyc(2'b01, 1'b1, 1'b1, 32'h55, 1'b0);
    chk("full_pop_rvalid", bus.mgr_rvalid_o, 2'b01);
    chk("full_pop_req", bus.sbr_req_o, 0);
    @(negedge clk);
    cyc(2'b01, 1'b1, 1'b0, '0, 1'b0);
    chk("full_reopen_req", bus.sbr_req_o, 1);
    @(negedge clk);
    drain();

    // response routing 1,0,1 with err on the second
    do_reset();
    cyc(2'b10, 1'b1, 1'b0, '0, 1'b0); chk("route_g0", bus.mgr_gnt_o, 2'b10); @(negedge clk);
    cyc(2'b01, 1'b1, 1'b0, '0, 1'b0); chk("route_g1", bus.mgr_gnt_o, 2'b01); @(negedge clk);
    cyc(2'b10, 1'b1, 1'b0, '0, 1'b0); chk("route_g2", bus.mgr_gnt_o, 2'b10); @(negedge clk);
    cyc('0, 1'b0, 1'b1, 32'hA, 1'b0);
    chk("route_rv0", bus.mgr_rvalid_o, 2'b10); chk("route_d0", bus.mgr_rdata_o, 32'hA);
    @(negedge clk);
    cyc('0, 1'b0, 1'b1, 32'hB, 1'b1);
    chk("route_rv1", bus.mgr_rvalid_o, 2'b01); chk("route_e1", bus.mgr_err_o, 1);
    @(negedge clk);
    cyc('0, 1'b0, 1'b1, 32'hC, 1'b0);
    chk("route_rv2", bus.mgr_rvalid_o, 2'b10); chk("route_e2", bus.mgr_err_o, 0);
    @(negedge clk);

    // spurious response: dropped, sticky protocol error until reset
    cyc('0, 1'b0, 1'b1, 32'hDEAD, 1'b1);
    chk("spur_rvalid", bus.mgr_rvalid_o, 0);
    @(negedge clk);
    repeat (3) begin
      cyc('0, 1'b0, 1'b0, '0, 1'b0);
      chk("spur_sticky", perr, 1);
      @(negedge clk);
    end
    do_reset();

    // random mix; request held while locked, responses only when outstanding
    for (int k = 0; k < 80; k++) begin
      logic [NM-1:0] rq;
      bit rv;
      rq = NM'($urandom_range(0, 3));
      if (m_lock) rq[m_lidx] = 1'b1;
      rv = (sb.size() > 0) && ($urandom_range(0, 2) != 0);
      cyc(rq, 1'($urandom_range(0, 1)), rv, $urandom, 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
